// File: rtl/hazard5_ahbl_arbiter.sv
// hazard5_ahbl_arbiter
// Merges N_PORTS Hazard5-style bus request ports onto one AHB-Lite master.
// Arbitration is either fixed priority (port 0 highest) or round-robin, and
// a panic bit on a request lifts it above all non-panic requests. Once an
// address phase has been presented under a wait state, it is held until
// accepted. Data-phase ownership is tracked so that each response is steered
// back to the port that issued it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_aph_req/panic     per-port request and urgent qualifier
//   req_haddr/hsize/hwrite per-port address-phase attributes (packed by port)
//   req_wdata             per-port write data, taken during that port's data phase
//   req_aph_ready         one-hot: address phase accepted this cycle
//   req_dph_ready/err     one-hot: data phase finished (with error)
//   req_rdata             read data broadcast to all ports
//   haddr..hrdata         AHB-Lite master interface
module hazard5_ahbl_arbiter #(
  parameter int          N_PORTS  = 2,
  parameter int          W_ADDR   = 32,
  parameter int          W_DATA   = 32,
  parameter int          ARB_MODE = 0,
  parameter logic [3:0]  HPROT    = 4'b0010
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          req_aph_req,
  input  logic [N_PORTS-1:0]          req_aph_panic,
  input  logic [N_PORTS*W_ADDR-1:0]   req_haddr,
  input  logic [N_PORTS*3-1:0]        req_hsize,
  input  logic [N_PORTS-1:0]          req_hwrite,
  input  logic [N_PORTS*W_DATA-1:0]   req_wdata,
  output logic [N_PORTS-1:0]          req_aph_ready,
  output logic [N_PORTS-1:0]          req_dph_ready,
  output logic [N_PORTS-1:0]          req_dph_err,
  output logic [W_DATA-1:0]           req_rdata,
  output logic [W_ADDR-1:0]           haddr,
  output logic                        hwrite,
  output logic [1:0]                  htrans,
  output logic [2:0]                  hsize,
  output logic [2:0]                  hburst,
  output logic [3:0]                  hprot,
  output logic                        hmastlock,
  input  logic                        hready,
  input  logic                        hresp,
  output logic [W_DATA-1:0]           hwdata,
  input  logic [W_DATA-1:0]           hrdata
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0] panic_set;
  logic [N_PORTS-1:0] cand;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      arb_port;
  logic               arb_found;
  logic [PW-1:0]      hi_port;
  logic               hi_found;
  logic [PW-1:0]      lo_port;
  logic               lo_found;
  logic [PW-1:0]      grant;
  logic               grant_valid;
  logic               aph_hold;
  logic [PW-1:0]      hold_port;
  logic               dph_valid;
  logic [PW-1:0]      dph_port;
  logic [PW-1:0]      wdata_sel;
  logic               err_first;
  logic               nseq;
  logic               aph_accept;

  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign hprot     = HPROT;
  assign req_rdata = hrdata;

  // Panic requests, if any, exclude all ordinary requests from arbitration.
  assign panic_set = req_aph_req & req_aph_panic;
  assign cand      = (|panic_set) ? panic_set : req_aph_req;

  // lo_* is the lowest-index candidate overall; hi_* is the lowest-index
  // candidate at or above rr_ptr. Round-robin prefers hi_* and falls back to
  // lo_*, which is the wrap-around case.
  always_comb begin
    lo_found = 1'b0;
    lo_port  = '0;
    hi_found = 1'b0;
    hi_port  = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (cand[k]) begin
        lo_found = 1'b1;
        lo_port  = PW'(k);
        if (PW'(k) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_port  = PW'(k);
        end
      end
    end
    if (ARB_MODE == 0) begin
      arb_found = lo_found;
      arb_port  = lo_port;
    end else begin
      arb_found = lo_found;
      arb_port  = hi_found ? hi_port : lo_port;
    end
  end

  // A presented address phase must stay on the bus until accepted, so a
  // held port overrides any fresh arbitration decision, panic included.
  assign grant_valid = aph_hold | arb_found;
  assign grant       = aph_hold ? hold_port : arb_port;

  // First cycle of a two-cycle error response: a new transfer may not be
  // started, but one already on the bus must not be withdrawn.
  assign err_first  = dph_valid & hresp & ~hready;
  assign nseq       = rst_n & grant_valid & (aph_hold | ~err_first);
  assign aph_accept = nseq & hready;
  assign htrans     = nseq ? 2'b10 : 2'b00;

  always_comb begin
    haddr  = req_haddr[0 +: W_ADDR];
    hsize  = req_hsize[0 +: 3];
    hwrite = req_hwrite[0];
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant == PW'(k)) begin
        haddr  = req_haddr[k*W_ADDR +: W_ADDR];
        hsize  = req_hsize[k*3 +: 3];
        hwrite = req_hwrite[k];
      end
    end
  end

  assign wdata_sel = dph_valid ? dph_port : '0;

  always_comb begin
    hwdata = req_wdata[0 +: W_DATA];
    for (int k = 0; k < N_PORTS; k++) begin
      if (wdata_sel == PW'(k)) begin
        hwdata = req_wdata[k*W_DATA +: W_DATA];
      end
    end
  end

  always_comb begin
    req_aph_ready = '0;
    req_dph_ready = '0;
    req_dph_err   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      req_aph_ready[k] = aph_accept && (grant == PW'(k));
      req_dph_ready[k] = dph_valid && hready && (dph_port == PW'(k));
      req_dph_err[k]   = dph_valid && hready && hresp && (dph_port == PW'(k));
    end
  end

  // Address-phase hold and data-phase ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aph_hold  <= 1'b0;
      hold_port <= '0;
      dph_valid <= 1'b0;
      dph_port  <= '0;
    end else if (hready) begin
      aph_hold  <= 1'b0;
      dph_valid <= nseq;
      dph_port  <= grant;
    end else if (nseq) begin
      aph_hold  <= 1'b1;
      hold_port <= grant;
    end
  end

  // Round-robin pointer: next search starts just after the last winner.
  // Constant zero in fixed-priority mode or with a single port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (aph_accept && (ARB_MODE != 0)) begin
      rr_ptr <= (grant == PW'(N_PORTS - 1)) ? '0 : grant + PW'(1);
    end
  end

endmodule

// File: tb/tb_hazard5_ahbl_arbiter.sv
module tb_hazard5_ahbl_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  panic;
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [2:0]  write_a;
  logic [95:0] req_haddr;
  logic [95:0] req_wdata;
  logic [8:0]  req_hsize;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  logic [2:0]  fx_aph_ready, fx_dph_ready, fx_dph_err;
  logic [31:0] fx_rdata, fx_haddr, fx_hwdata;
  logic        fx_hwrite, fx_hmastlock;
  logic [1:0]  fx_htrans;
  logic [2:0]  fx_hsize, fx_hburst;
  logic [3:0]  fx_hprot;

  logic [2:0]  rr_aph_ready, rr_dph_ready, rr_dph_err;
  logic [31:0] rr_rdata, rr_haddr, rr_hwdata;
  logic        rr_hwrite, rr_hmastlock;
  logic [1:0]  rr_htrans;
  logic [2:0]  rr_hsize, rr_hburst;
  logic [3:0]  rr_hprot;

  int checks = 0;
  int failures = 0;

  assign req_haddr = {addr_a[2], addr_a[1], addr_a[0]};
  assign req_wdata = {wdata_a[2], wdata_a[1], wdata_a[0]};
  assign req_hsize = {3'b010, 3'b010, 3'b010};

  always #5 clk = ~clk;

  hazard5_ahbl_arbiter #(.N_PORTS(3), .W_ADDR(32), .W_DATA(32), .ARB_MODE(0), .HPROT(4'b0010)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req_aph_req(req), .req_aph_panic(panic), .req_haddr(req_haddr),
    .req_hsize(req_hsize), .req_hwrite(write_a), .req_wdata(req_wdata),
    .req_aph_ready(fx_aph_ready), .req_dph_ready(fx_dph_ready), .req_dph_err(fx_dph_err),
    .req_rdata(fx_rdata), .haddr(fx_haddr), .hwrite(fx_hwrite), .htrans(fx_htrans),
    .hsize(fx_hsize), .hburst(fx_hburst), .hprot(fx_hprot), .hmastlock(fx_hmastlock),
    .hready(hready), .hresp(hresp), .hwdata(fx_hwdata), .hrdata(hrdata)
  );

  hazard5_ahbl_arbiter #(.N_PORTS(3), .W_ADDR(32), .W_DATA(32), .ARB_MODE(1), .HPROT(4'b0010)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req_aph_req(req), .req_aph_panic(panic), .req_haddr(req_haddr),
    .req_hsize(req_hsize), .req_hwrite(write_a), .req_wdata(req_wdata),
    .req_aph_ready(rr_aph_ready), .req_dph_ready(rr_dph_ready), .req_dph_err(rr_dph_err),
    .req_rdata(rr_rdata), .haddr(rr_haddr), .hwrite(rr_hwrite), .htrans(rr_htrans),
    .hsize(rr_hsize), .hburst(rr_hburst), .hprot(rr_hprot), .hmastlock(rr_hmastlock),
    .hready(hready), .hresp(hresp), .hwdata(rr_hwdata), .hrdata(hrdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    panic   = '0;
    write_a = '0;
    hready  = 1'b1;
    hresp   = 1'b0;
    hrdata  = '0;
    for (int p = 0; p < 3; p++) begin
      addr_a[p]  = 32'h1000 + 32'(p * 4);
      wdata_a[p] = 32'h5000_0000 + 32'(p);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b111; panic = 3'b000; hready = 1'b1; hresp = 1'b0;
    wdata_a[0] = 32'hA5A5_0001; wdata_a[1] = 32'hA5A5_0002; wdata_a[2] = 32'hA5A5_0003;
    hrdata = 32'hCAFE_F00D;
    #2;
    checks++; if (fx_htrans !== 2'b00) begin failures++; $display("FAIL reset_htrans got %h want 0", fx_htrans); end
    checks++; if (rr_htrans !== 2'b00) begin failures++; $display("FAIL reset_rr_htrans got %h want 0", rr_htrans); end
    checks++; if ({fx_aph_ready, fx_dph_ready, fx_dph_err} !== 9'd0) begin failures++; $display("FAIL reset_ready got %b%b%b want 0", fx_aph_ready, fx_dph_ready, fx_dph_err); end
    checks++; if (fx_hwdata !== 32'hA5A5_0001) begin failures++; $display("FAIL reset_hwdata got %h want a5a50001", fx_hwdata); end
    checks++; if ({fx_hburst, fx_hprot, fx_hmastlock} !== {3'b000, 4'b0010, 1'b0}) begin failures++; $display("FAIL const_outs got %b %b %b", fx_hburst, fx_hprot, fx_hmastlock); end
    checks++; if ({rr_hburst, rr_hprot, rr_hmastlock} !== {3'b000, 4'b0010, 1'b0}) begin failures++; $display("FAIL rr_const_outs got %b %b %b", rr_hburst, rr_hprot, rr_hmastlock); end
    checks++; if (fx_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL rdata_pass got %h want cafef00d", fx_rdata); end
    do_reset();
  endtask

  task automatic test_fixed_b2b();
    do_reset();
    req = 3'b011;
    #2;
    checks++; if (fx_aph_ready !== 3'b001) begin failures++; $display("FAIL b2b_c0_aph got %b want 001", fx_aph_ready); end
    checks++; if (fx_haddr !== 32'h1000 || fx_htrans !== 2'b10) begin failures++; $display("FAIL b2b_c0_addr got %h/%h want 1000/2", fx_haddr, fx_htrans); end
    checks++; if (fx_hsize !== 3'b010) begin failures++; $display("FAIL b2b_hsize got %b want 010", fx_hsize); end
    tick();
    req = 3'b010;
    #2;
    checks++; if (fx_aph_ready !== 3'b010) begin failures++; $display("FAIL b2b_c1_aph got %b want 010", fx_aph_ready); end
    checks++; if (fx_dph_ready !== 3'b001) begin failures++; $display("FAIL b2b_c1_dph got %b want 001", fx_dph_ready); end
    tick();
    req = 3'b000;
    #2;
    checks++; if (fx_dph_ready !== 3'b010) begin failures++; $display("FAIL b2b_c2_dph got %b want 010", fx_dph_ready); end
    checks++; if (fx_htrans !== 2'b00 || fx_aph_ready !== 3'b000) begin failures++; $display("FAIL b2b_c2_idle got %h/%b want 0/000", fx_htrans, fx_aph_ready); end
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    addr_a[1] = 32'h2000;
    req = 3'b010; hready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin req = 3'b011; panic = 3'b001; end
      #2;
      checks++; if (fx_haddr !== 32'h2000 || fx_htrans !== 2'b10) begin failures++; $display("FAIL hold_c%0d got %h/%h want 2000/2", c, fx_haddr, fx_htrans); end
      checks++; if (fx_aph_ready !== 3'b000) begin failures++; $display("FAIL hold_aph_c%0d got %b want 000", c, fx_aph_ready); end
      tick();
    end
    hready = 1'b1;
    #2;
    checks++; if (fx_aph_ready !== 3'b010 || fx_haddr !== 32'h2000) begin failures++; $display("FAIL hold_release got %b/%h want 010/2000", fx_aph_ready, fx_haddr); end
    tick();
    req = 3'b001;
    #2;
    checks++; if (fx_aph_ready !== 3'b001 || fx_haddr !== 32'h1000) begin failures++; $display("FAIL hold_next got %b/%h want 001/1000", fx_aph_ready, fx_haddr); end
    checks++; if (fx_dph_ready !== 3'b010) begin failures++; $display("FAIL hold_dph got %b want 010", fx_dph_ready); end
    tick();
    req = 3'b000; panic = 3'b000;
  endtask

  task automatic test_panic();
    do_reset();
    req = 3'b011; panic = 3'b010;
    #2;
    checks++; if (fx_aph_ready !== 3'b010 || fx_haddr !== 32'h1004) begin failures++; $display("FAIL panic_first got %b/%h want 010/1004", fx_aph_ready, fx_haddr); end
    tick();
    req = 3'b001; panic = 3'b000;
    #2;
    checks++; if (fx_aph_ready !== 3'b001) begin failures++; $display("FAIL panic_second got %b want 001", fx_aph_ready); end
    tick();
    req = 3'b000;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      exp = 3'b001 << (i % 3);
      #2;
      checks++; if (rr_aph_ready !== exp) begin failures++; $display("FAIL rr_order_%0d got %b want %b", i, rr_aph_ready, exp); end
      tick();
    end
    req = 3'b000;
  endtask

  task automatic test_wdata_rdata();
    do_reset();
    addr_a[0] = 32'h3000; write_a = 3'b001; wdata_a[0] = 32'hDEAD_BEEF;
    addr_a[1] = 32'h3004; wdata_a[1] = 32'h0BAD_F00D;
    req = 3'b011;
    #2;
    checks++; if (fx_aph_ready !== 3'b001 || fx_hwrite !== 1'b1) begin failures++; $display("FAIL wr_aph got %b/%b want 001/1", fx_aph_ready, fx_hwrite); end
    tick();
    req = 3'b010;
    #2;
    checks++; if (fx_hwdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hwdata got %h want deadbeef", fx_hwdata); end
    checks++; if (fx_aph_ready !== 3'b010 || fx_hwrite !== 1'b0) begin failures++; $display("FAIL rd_aph got %b/%b want 010/0", fx_aph_ready, fx_hwrite); end
    tick();
    req = 3'b000; hrdata = 32'h1234_5678;
    #2;
    checks++; if (fx_dph_ready !== 3'b010) begin failures++; $display("FAIL rd_dph got %b want 010", fx_dph_ready); end
    checks++; if (fx_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rd_rdata got %h want 12345678", fx_rdata); end
    checks++; if (fx_hwdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL rd_hwdata_owner got %h want 0badf00d", fx_hwdata); end
    tick();
    write_a = 3'b000;
  endtask

  task automatic test_error_and_reset();
    do_reset();
    req = 3'b001;
    #2;
    checks++; if (fx_aph_ready !== 3'b001) begin failures++; $display("FAIL err_aph got %b want 001", fx_aph_ready); end
    tick();
    req = 3'b010; hresp = 1'b1; hready = 1'b0;
    #2;
    checks++; if (fx_htrans !== 2'b00) begin failures++; $display("FAIL err_first_idle got %h want 0", fx_htrans); end
    checks++; if ({fx_aph_ready, fx_dph_ready, fx_dph_err} !== 9'd0) begin failures++; $display("FAIL err_first_quiet got %b%b%b want 0", fx_aph_ready, fx_dph_ready, fx_dph_err); end
    tick();
    hready = 1'b1;
    #2;
    checks++; if (fx_dph_err !== 3'b001 || fx_dph_ready !== 3'b001) begin failures++; $display("FAIL err_second got %b/%b want 001/001", fx_dph_err, fx_dph_ready); end
    checks++; if (fx_htrans !== 2'b10 || fx_aph_ready !== 3'b010) begin failures++; $display("FAIL err_next_aph got %h/%b want 2/010", fx_htrans, fx_aph_ready); end
    tick();
    req = 3'b000; hresp = 1'b0; hready = 1'b0;
    #2;
    hready = 1'b1;
    #1;
    checks++; if (fx_dph_ready !== 3'b010) begin failures++; $display("FAIL pre_rst_dph got %b want 010", fx_dph_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if ({fx_aph_ready, fx_dph_ready, fx_dph_err} !== 9'd0 || fx_htrans !== 2'b00) begin failures++; $display("FAIL mid_rst got %b%b%b/%h want 0", fx_aph_ready, fx_dph_ready, fx_dph_err, fx_htrans); end
    checks++; if (fx_hwdata !== wdata_a[0]) begin failures++; $display("FAIL mid_rst_hwdata got %h want %h", fx_hwdata, wdata_a[0]); end
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: transactions per port are outstanding until accepted;
  // owner/held are port numbers, -1 meaning none.
  task automatic test_random(input int mode, input int ncyc);
    int owner, held, rr, g, idx;
    logic [2:0] pend, pset, cset, exp_aph, exp_dph;
    logic [1:0] o_htrans;
    logic [31:0] o_haddr, o_hwdata;
    logic [2:0] o_aph, o_dph;
    logic o_hwrite;
    do_reset();
    owner = -1; held = -1; rr = 0; pend = '0;
    for (int c = 0; c < ncyc; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1'b1;
          addr_a[p]  = $urandom & 32'hFFFF_FFFC;
          write_a[p] = 1'($urandom_range(0, 1));
        end
        wdata_a[p] = $urandom;
        panic[p]   = ($urandom_range(0, 3) == 0);
      end
      req    = pend;
      hready = ($urandom_range(0, 3) != 0);
      hresp  = 1'b0;
      hrdata = $urandom;
      #2;
      pset = req & panic;
      cset = (pset != 0) ? pset : req;
      g = -1;
      if (held >= 0) g = held;
      else if (mode == 0) begin
        for (int i = 2; i >= 0; i--) if (cset[i]) g = i;
      end else begin
        for (int i = 0; i < 3; i++) begin
          idx = (rr + i) % 3;
          if (g < 0 && cset[idx]) g = idx;
        end
      end
      exp_aph = (g >= 0 && hready) ? (3'b001 << g) : 3'b000;
      exp_dph = (owner >= 0 && hready) ? (3'b001 << owner) : 3'b000;
      o_htrans = mode ? rr_htrans : fx_htrans;
      o_haddr  = mode ? rr_haddr : fx_haddr;
      o_hwrite = mode ? rr_hwrite : fx_hwrite;
      o_hwdata = mode ? rr_hwdata : fx_hwdata;
      o_aph    = mode ? rr_aph_ready : fx_aph_ready;
      o_dph    = mode ? rr_dph_ready : fx_dph_ready;
      checks++; if (o_htrans !== ((g >= 0) ? 2'b10 : 2'b00)) begin failures++; $display("FAIL rnd%0d_htrans c=%0d got %h want grant %0d", mode, c, o_htrans, g); end
      checks++; if (o_aph !== exp_aph) begin failures++; $display("FAIL rnd%0d_aph c=%0d got %b want %b", mode, c, o_aph, exp_aph); end
      checks++; if (o_dph !== exp_dph) begin failures++; $display("FAIL rnd%0d_dph c=%0d got %b want %b", mode, c, o_dph, exp_dph); end
      checks++; if (o_hwdata !== ((owner >= 0) ? wdata_a[owner] : wdata_a[0])) begin failures++; $display("FAIL rnd%0d_hwdata c=%0d got %h owner %0d", mode, c, o_hwdata, owner); end
      if (g >= 0) begin
        checks++; if (o_haddr !== addr_a[g] || o_hwrite !== write_a[g]) begin failures++; $display("FAIL rnd%0d_addr c=%0d got %h/%b want %h/%b", mode, c, o_haddr, o_hwrite, addr_a[g], write_a[g]); end
      end
      if (hready) begin
        owner = g;
        held  = -1;
        if (g >= 0) begin
          pend[g] = 1'b0;
          rr = (g + 1) % 3;
        end
      end else if (g >= 0) begin
        held = g;
      end
      tick();
    end
    req = '0; panic = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();
    test_reset();
    test_fixed_b2b();
    test_hold();
    test_panic();
    test_round_robin();
    test_wdata_rdata();
    test_error_and_reset();
    test_random(0, 400);
    test_random(1, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
